// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART_TX among N byte requesters.
// Captures the winner's byte and parity config, then sequences one frame per grant via BUSY.
module uart_tx_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned BUSY_TMO = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       req_data,
  input  logic [N-1:0]         par_en_cfg,
  input  logic [N-1:0]         par_typ_cfg,
  output logic [N-1:0]         ack,
  output logic [W-1:0]         tx_data,
  output logic                 tx_valid,
  output logic                 tx_par_en,
  output logic                 tx_par_typ,
  input  logic                 tx_busy,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 active,
  output logic                 err_tmo
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(BUSY_TMO) + 1;
  // Counter value at which one more idle BUSY cycle means the handshake has timed out.
  localparam logic [CW-1:0] TmoLast = CW'(BUSY_TMO - 2);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StLoad     = 2'd1;
  localparam logic [1:0] StWaitBusy = 2'd2;
  localparam logic [1:0] StWaitDone = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  ack_q;
  logic [W-1:0]  data_q;
  logic          valid_q;
  logic          par_en_q;
  logic          par_typ_q;
  logic [IW-1:0] grant_q;
  logic          active_q;
  logic          err_q, err_d;

  logic [W-1:0]  req_byte [N];
  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic          found;
  logic          grant;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_byte[i] = req_data[i*W +: W];
    end
  end

  // First requester at or after ptr, wrapping modulo N (N is a power of two).
  always_comb begin
    win   = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + IW'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign grant = (state_q == StIdle) && !tx_busy && found;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (grant) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else if (cnt_q == TmoLast) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          ptr_d   = grant_q + IW'(1);
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          ptr_d   = grant_q + IW'(1);
          state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ptr_q     <= '0;
      ack_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      grant_q   <= '0;
      active_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      valid_q  <= grant;
      err_q    <= err_d;
      active_q <= (state_d != StIdle);
      ack_q    <= '0;
      // Payload and config are sampled only here and held until the next grant.
      if (grant) begin
        ack_q[win] <= 1'b1;
        data_q     <= req_byte[win];
        par_en_q   <= par_en_cfg[win];
        par_typ_q  <= par_typ_cfg[win];
        grant_q    <= win;
      end
    end
  end

  assign ack        = ack_q;
  assign tx_data    = data_q;
  assign tx_valid   = valid_q;
  assign tx_par_en  = par_en_q;
  assign tx_par_typ = par_typ_q;
  assign grant_id   = grant_q;
  assign active     = active_q;
  assign err_tmo    = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed steps plus randomized frames against a
// transaction-level model of pending requests and the round-robin pointer.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TMO = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   par_en_cfg;
  logic [N-1:0]   par_typ_cfg;
  logic [N-1:0]   ack;
  logic [W-1:0]   tx_data;
  logic           tx_valid;
  logic           tx_par_en;
  logic           tx_par_typ;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           active;
  logic           err_tmo;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .W(W), .BUSY_TMO(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .par_en_cfg (par_en_cfg),
    .par_typ_cfg(par_typ_cfg),
    .ack        (ack),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_par_en  (tx_par_en),
    .tx_par_typ (tx_par_typ),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .active     (active),
    .err_tmo    (err_tmo)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: which requesters hold a byte, their bytes, and the round-robin start point.
  int           m_ptr;
  bit           pend [N];
  logic [W-1:0] byt  [N];
  int           cur_g;
  logic [W-1:0] exp_data;
  logic         exp_pe;
  logic         exp_pt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_req();
    for (int i = 0; i < N; i++) begin
      req[i]             = pend[i];
      req_data[i*W +: W] = byt[i];
    end
  endtask

  function automatic int pick();
    int w;
    w = -1;
    for (int k = N - 1; k >= 0; k--) begin
      if (pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    end
    return w;
  endfunction

  // Called at a negedge with the DUT idle; renew: 0 drop, 1 new byte, 2 same byte.
  task automatic grant(input int renew);
    int g;
    apply_req();
    g        = pick();
    cur_g    = g;
    exp_data = byt[g];
    exp_pe   = par_en_cfg[g];
    exp_pt   = par_typ_cfg[g];
    @(negedge clk);
    check("ack", ack, 32'(1) << g);
    check("tx_valid", tx_valid, 1);
    check("tx_data", tx_data, exp_data);
    check("tx_par_en", tx_par_en, exp_pe);
    check("tx_par_typ", tx_par_typ, exp_pt);
    check("grant_id", grant_id, g);
    check("active_load", active, 1);
    check("err_tmo_load", err_tmo, 0);
    if (renew == 0) pend[g] = 1'b0;
    else if (renew == 1) byt[g] = W'($urandom);
    apply_req();
  endtask

  // Busy rises at the k-th negedge after the ack and stays up for len negedges (len >= 2).
  task automatic frame(input int k, input int len);
    for (int c = 1; c < k; c++) begin
      @(negedge clk);
      check("wait_valid", tx_valid, 0);
      check("wait_ack", ack, 0);
      check("wait_active", active, 1);
    end
    tx_busy = 1'b1;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      check("frame_active", active, 1);
      check("frame_err", err_tmo, 0);
      check("frame_ack", ack, 0);
      check("frame_data", tx_data, exp_data);
      check("frame_par_en", tx_par_en, exp_pe);
      check("frame_par_typ", tx_par_typ, exp_pt);
      par_typ_cfg[cur_g] = ~par_typ_cfg[cur_g];
      par_en_cfg         = N'($urandom);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    check("done_active", active, 0);
    check("done_valid", tx_valid, 0);
    check("done_data", tx_data, exp_data);
    check("done_par_typ", tx_par_typ, exp_pt);
    m_ptr = (cur_g + 1) % N;
  endtask

  task automatic timeout_frame();
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check("tmo_wait_err", err_tmo, 0);
      check("tmo_wait_active", active, 1);
    end
    @(negedge clk);
    check("tmo_pulse", err_tmo, 1);
    check("tmo_idle", active, 0);
    m_ptr = (cur_g + 1) % N;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = '0; req_data = '0; par_en_cfg = '0; par_typ_cfg = '0; tx_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      byt[i]  = '0;
    end
    m_ptr = 0;
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_active", active, 0);
    check("rst_err", err_tmo, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single requester with even parity enabled.
    pend[2] = 1'b1; byt[2] = 8'hA5; par_en_cfg = 4'b0100; par_typ_cfg = 4'b0000;
    grant(0);
    frame(1, 10);

    // Fairness wrap from ptr=3: expect 3, 0, 3.
    pend[0] = 1'b1; byt[0] = 8'h5A; pend[3] = 1'b1; byt[3] = 8'h3C;
    grant(1);
    frame(2, 3);
    grant(0);
    frame(1, 2);
    grant(0);
    frame(3, 2);

    // Full contention with held requests.
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      byt[i]  = W'(8'h10 + i);
    end
    par_en_cfg = N'($urandom); par_typ_cfg = N'($urandom);
    for (int f = 0; f < 5; f++) begin
      grant(2);
      frame(int'($urandom_range(1, 3)), int'($urandom_range(2, 5)));
    end

    // BUSY never rises: timeout, then the pointer moves past the timed-out requester.
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    pend[1] = 1'b1; byt[1] = 8'h77;
    grant(0);
    timeout_frame();
    pend[1] = 1'b1; pend[2] = 1'b1; byt[2] = 8'hC3;
    grant(0);
    frame(1, 3);
    grant(0);
    timeout_frame();

    // BUSY held high in IDLE blocks grants.
    pend[3] = 1'b1; byt[3] = 8'hE1;
    tx_busy = 1'b1;
    apply_req();
    repeat (3) begin
      @(negedge clk);
      check("blocked_ack", ack, 0);
      check("blocked_valid", tx_valid, 0);
      check("blocked_active", active, 0);
    end
    tx_busy = 1'b0;
    grant(0);
    frame(2, 2);

    // Asynchronous reset during WAIT_DONE.
    pend[0] = 1'b1; byt[0] = 8'h42; pend[2] = 1'b1; byt[2] = 8'h99;
    grant(0);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_active", active, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_ack", ack, 0);
    check("arst_valid", tx_valid, 0);
    check("arst_data", tx_data, 0);
    check("arst_par", {tx_par_en, tx_par_typ}, 0);
    check("arst_grant_id", grant_id, 0);
    check("arst_active", active, 0);
    tx_busy = 1'b0;
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
    pend[0] = 1'b1; byt[0] = 8'h24;
    grant(0);
    frame(2, 3);

    // Randomized traffic.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          byt[i]  = W'($urandom);
        end
      end
      if (pick() < 0) begin
        pend[$urandom_range(0, N - 1)] = 1'b1;
        for (int i = 0; i < N; i++) if (pend[i]) byt[i] = W'($urandom);
      end
      par_en_cfg  = N'($urandom);
      par_typ_cfg = N'($urandom);
      grant(int'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) timeout_frame();
      else frame(int'($urandom_range(1, 3)), int'($urandom_range(2, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
